// File: rtl/axi4s_sample_packer.sv
// Packs pairs of 16-bit samples into 32-bit AXI4-Stream words framed into PKT_WORDS-word
// packets; a 2-entry output buffer absorbs stalls and words that do not fit are counted.
module axi4s_sample_packer #(
    parameter int PKT_WORDS = 256,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 ACLK,
    input  logic                 ARESET,
    input  logic                 enable,
    input  logic                 clear_stats,
    input  logic                 sample_valid,
    input  logic [15:0]          sample_data,
    output logic [31:0]          m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 m_axis_tlast,
    output logic [CNT_WIDTH-1:0] overflow_count,
    output logic                 overflow_sticky
);

    localparam int PW = (PKT_WORDS > 2) ? $clog2(PKT_WORDS) : 1;
    localparam logic [PW-1:0] LAST_POS = PW'(PKT_WORDS - 1);

    logic          phase;
    logic [15:0]   low_half;
    logic [PW-1:0] pkt_cnt;
    logic [1:0]    occ;
    logic [31:0]   head_data, tail_data;
    logic          head_last, tail_last;

    logic          word_done, word_last, push, pop, drop;
    logic [31:0]   word;

    assign word_done = sample_valid & enable & phase;
    assign word      = {sample_data, low_half};
    assign word_last = (pkt_cnt == LAST_POS);

    // tvalid comes only from registered occupancy, so tready never reaches it combinationally
    assign pop  = (occ != 2'd0) & m_axis_tready;
    assign push = word_done & ((occ != 2'd2) | pop);
    assign drop = word_done & ~push;

    assign m_axis_tvalid = (occ != 2'd0);
    assign m_axis_tdata  = head_data;
    assign m_axis_tlast  = head_last;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            phase           <= 1'b0;
            low_half        <= '0;
            pkt_cnt         <= '0;
            occ             <= 2'd0;
            head_data       <= '0;
            head_last       <= 1'b0;
            tail_data       <= '0;
            tail_last       <= 1'b0;
            overflow_count  <= '0;
            overflow_sticky <= 1'b0;
        end else begin
            if (sample_valid && enable) begin
                if (!phase)
                    low_half <= sample_data;
                phase <= ~phase;
            end else if (!enable) begin
                phase <= 1'b0;
            end

            case ({push, pop})
                2'b10: begin
                    if (occ == 2'd0) begin
                        head_data <= word;
                        head_last <= word_last;
                    end else begin
                        tail_data <= word;
                        tail_last <= word_last;
                    end
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    head_data <= tail_data;
                    head_last <= tail_last;
                    occ       <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        head_data <= word;
                        head_last <= word_last;
                    end else begin
                        head_data <= tail_data;
                        head_last <= tail_last;
                        tail_data <= word;
                        tail_last <= word_last;
                    end
                end
                default: ;
            endcase

            // Dropped words leave the packet position alone so delivered framing stays intact
            if (push)
                pkt_cnt <= word_last ? '0 : pkt_cnt + 1'b1;

            if (clear_stats) begin
                overflow_count  <= drop ? CNT_WIDTH'(1) : '0;
                overflow_sticky <= drop;
            end else if (drop) begin
                overflow_sticky <= 1'b1;
                if (overflow_count != '1)
                    overflow_count <= overflow_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axi4s_sample_packer.sv
// Directed bench for axi4s_sample_packer: expected words queued by stimulus, checked by a
// monitor on every handshake; stats and latency checked inline.
module tb_axi4s_sample_packer;

    logic        ACLK = 1'b0;
    logic        ARESET, enable, clear_stats, sample_valid;
    logic [15:0] sample_data;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid, m_axis_tready, m_axis_tlast;
    logic [3:0]  overflow_count;
    logic        overflow_sticky;

    int errors = 0;
    int checks = 0;
    logic [32:0] exp_q[$];

    axi4s_sample_packer #(.PKT_WORDS(4), .CNT_WIDTH(4)) dut (
        .ACLK(ACLK), .ARESET(ARESET), .enable(enable), .clear_stats(clear_stats),
        .sample_valid(sample_valid), .sample_data(sample_data),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .overflow_count(overflow_count), .overflow_sticky(overflow_sticky)
    );

    always #5 ACLK = ~ACLK;

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every handshake pops one expected {tlast,tdata}; held words must not change
    logic        prev_hold = 1'b0;
    logic [32:0] prev_word = '0;
    always @(negedge ACLK) begin
        if (ARESET) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold)
                check("hold_stable", {m_axis_tvalid, m_axis_tlast, m_axis_tdata},
                      {1'b1, prev_word});
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() == 0)
                    check("unexpected_word", {m_axis_tlast, m_axis_tdata}, 33'h1_FFFF_FFFF);
                else
                    check("word", {m_axis_tlast, m_axis_tdata}, exp_q.pop_front());
            end
            prev_hold = m_axis_tvalid && !m_axis_tready;
            prev_word = {m_axis_tlast, m_axis_tdata};
        end
    end

    task automatic tick;
        @(posedge ACLK);
        #1;
    endtask

    task automatic do_reset;
        ARESET = 1'b1;
        tick();
        ARESET = 1'b0;
    endtask

    // Two back-to-back samples forming one word; optional latency check and clear pulse
    task automatic send_word(input logic [15:0] lo, input logic [15:0] hi,
                             input bit lat, input bit cs);
        sample_valid = 1'b1;
        sample_data  = lo;
        tick();
        if (lat) check("lat_half", {32'd0, m_axis_tvalid}, 33'd0);
        sample_data = hi;
        clear_stats = cs;
        tick();
        clear_stats = 1'b0;
        if (lat) check("lat_word", {32'd0, m_axis_tvalid}, 33'd1);
        sample_valid = 1'b0;
    endtask

    task automatic drain;
        int i;
        for (i = 0; i < 200 && exp_q.size() > 0; i++) tick();
        check("drain", {1'b0, 32'(exp_q.size())}, 33'd0);
        tick();
        tick();
    endtask

    initial begin
        ARESET = 1'b1; enable = 1'b1; clear_stats = 1'b0; sample_valid = 1'b0;
        sample_data = '0; m_axis_tready = 1'b0;
        tick();
        check("rst_tvalid", {32'd0, m_axis_tvalid}, 33'd0);
        check("rst_tdata", {m_axis_tlast, m_axis_tdata}, 33'd0);
        check("rst_stats", {28'd0, overflow_sticky, overflow_count}, 33'd0);
        ARESET = 1'b0;

        // 1: straight-through packing and framing
        m_axis_tready = 1'b1;
        exp_q.push_back({1'b0, 32'h0002_0001});
        exp_q.push_back({1'b0, 32'h0004_0003});
        exp_q.push_back({1'b0, 32'h0006_0005});
        exp_q.push_back({1'b1, 32'h0008_0007});
        send_word(16'h0001, 16'h0002, 1'b1, 1'b0);
        send_word(16'h0003, 16'h0004, 1'b1, 1'b0);
        send_word(16'h0005, 16'h0006, 1'b1, 1'b0);
        send_word(16'h0007, 16'h0008, 1'b1, 1'b0);
        drain();

        // 2: stalled output, two drops, framing continues at positions 2,3
        do_reset();
        m_axis_tready = 1'b0;
        exp_q.push_back({1'b0, 32'h0002_0001});
        exp_q.push_back({1'b0, 32'h0004_0003});
        send_word(16'h0001, 16'h0002, 1'b0, 1'b0);
        send_word(16'h0003, 16'h0004, 1'b0, 1'b0);
        send_word(16'h0005, 16'h0006, 1'b0, 1'b0);
        send_word(16'h0007, 16'h0008, 1'b0, 1'b0);
        check("t2_count", {29'd0, overflow_count}, 33'd2);
        check("t2_sticky", {32'd0, overflow_sticky}, 33'd1);
        m_axis_tready = 1'b1;
        drain();
        exp_q.push_back({1'b0, 32'h000A_0009});
        exp_q.push_back({1'b1, 32'h000C_000B});
        send_word(16'h0009, 16'h000A, 1'b0, 1'b0);
        send_word(16'h000B, 16'h000C, 1'b0, 1'b0);
        drain();

        // 3: enable gap discards the held half-sample
        do_reset();
        sample_valid = 1'b1; sample_data = 16'h00AA;
        tick();
        enable = 1'b0; sample_data = 16'h00BB;
        repeat (3) tick();
        enable = 1'b1; sample_valid = 1'b0;
        exp_q.push_back({1'b0, 32'h0022_0011});
        send_word(16'h0011, 16'h0022, 1'b0, 1'b0);
        drain();

        // 4: push and pop together on a full buffer
        do_reset();
        m_axis_tready = 1'b0;
        exp_q.push_back({1'b0, 32'h0002_0001});
        exp_q.push_back({1'b0, 32'h0004_0003});
        exp_q.push_back({1'b0, 32'h0006_0005});
        exp_q.push_back({1'b1, 32'h0008_0007});
        send_word(16'h0001, 16'h0002, 1'b0, 1'b0);
        send_word(16'h0003, 16'h0004, 1'b0, 1'b0);
        sample_valid = 1'b1; sample_data = 16'h0005;
        tick();
        sample_data = 16'h0006; m_axis_tready = 1'b1;
        tick();
        m_axis_tready = 1'b0; sample_valid = 1'b0;
        check("t4_count", {29'd0, overflow_count}, 33'd0);
        check("t4_sticky", {32'd0, overflow_sticky}, 33'd0);
        m_axis_tready = 1'b1;
        send_word(16'h0007, 16'h0008, 1'b0, 1'b0);
        drain();

        // 5: reset mid-packet with a buffered word and a held half-sample
        m_axis_tready = 1'b0;
        send_word(16'h0001, 16'h0002, 1'b0, 1'b0);
        sample_valid = 1'b1; sample_data = 16'h0003;
        tick();
        sample_valid = 1'b0;
        do_reset();
        check("t5_tvalid", {32'd0, m_axis_tvalid}, 33'd0);
        check("t5_count", {29'd0, overflow_count}, 33'd0);
        m_axis_tready = 1'b1;
        exp_q.push_back({1'b0, 32'h0002_0001});
        exp_q.push_back({1'b0, 32'h0004_0003});
        exp_q.push_back({1'b0, 32'h0006_0005});
        exp_q.push_back({1'b1, 32'h0008_0007});
        send_word(16'h0001, 16'h0002, 1'b0, 1'b0);
        send_word(16'h0003, 16'h0004, 1'b0, 1'b0);
        send_word(16'h0005, 16'h0006, 1'b0, 1'b0);
        send_word(16'h0007, 16'h0008, 1'b0, 1'b0);
        drain();

        // 6: clear coincident with a drop, then saturation
        do_reset();
        m_axis_tready = 1'b0;
        exp_q.push_back({1'b0, 32'h0202_0101});
        exp_q.push_back({1'b0, 32'h0404_0303});
        send_word(16'h0101, 16'h0202, 1'b0, 1'b0);
        send_word(16'h0303, 16'h0404, 1'b0, 1'b0);
        repeat (5) send_word(16'hDEAD, 16'hBEEF, 1'b0, 1'b0);
        check("t6_count5", {29'd0, overflow_count}, 33'd5);
        send_word(16'hDEAD, 16'hBEEF, 1'b0, 1'b1);
        check("t6_clr_drop", {28'd0, overflow_sticky, overflow_count}, {28'd0, 1'b1, 4'd1});
        clear_stats = 1'b1;
        tick();
        clear_stats = 1'b0;
        check("t6_clr", {28'd0, overflow_sticky, overflow_count}, 33'd0);
        repeat (20) send_word(16'hDEAD, 16'hBEEF, 1'b0, 1'b0);
        check("t6_sat", {28'd0, overflow_sticky, overflow_count}, {28'd0, 1'b1, 4'hF});
        m_axis_tready = 1'b1;
        drain();

        check("queue_empty", {1'b0, 32'(exp_q.size())}, 33'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
